// File: rtl/l2_request_responder.sv
// l2_request_responder: in-order L1 miss/writeback request queue with a fixed-latency
// access to the L2 line array; reads complete with a registered one-cycle done pulse.
module l2_request_responder #(
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = 128,
    parameter int DEPTH      = 4,
    parameter int ACCESS_LAT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_l2,
    input  logic              rw_l2,
    input  logic [ADDR_W-1:0] addr_l2,
    input  logic [LINE_W-1:0] wdata_l2,
    output logic              stall_l2,
    output logic              done_l2,
    output logic [LINE_W-1:0] rdata_l2,
    output logic [ADDR_W-1:0] done_addr,
    output logic              arr_en,
    output logic              arr_we,
    output logic [ADDR_W-1:0] arr_addr,
    output logic [LINE_W-1:0] arr_wdata,
    input  logic [LINE_W-1:0] arr_rdata
);
    localparam int PW    = $clog2(DEPTH);
    localparam int LAT_W = $clog2(ACCESS_LAT) + 1;

    typedef enum logic [1:0] {IDLE, WAIT_LAT, ACCESS, RESPOND} state_t;

    state_t             state, state_nxt;
    logic [PW:0]        count;
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [LAT_W-1:0]   lat_cnt;
    logic               q_rw    [DEPTH];
    logic [ADDR_W-1:0]  q_addr  [DEPTH];
    logic [LINE_W-1:0]  q_wdata [DEPTH];
    logic               cur_rw;
    logic [ADDR_W-1:0]  cur_addr;
    logic [LINE_W-1:0]  cur_wdata;
    logic               push, pop;

    // Stall depends only on the registered count, never on valid_l2.
    assign stall_l2 = count == (PW+1)'(DEPTH);
    assign push     = valid_l2 && !stall_l2;
    assign pop      = state == IDLE && count != '0;

    always_ff @(posedge clock) begin
        if (push) begin
            q_rw[wr_ptr]    <= rw_l2;
            q_addr[wr_ptr]  <= addr_l2;
            q_wdata[wr_ptr] <= wdata_l2;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lat_cnt   <= '0;
            state     <= IDLE;
            cur_rw    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
        end else begin
            state  <= state_nxt;
            count  <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            if (pop) begin
                cur_rw    <= q_rw[rd_ptr];
                cur_addr  <= q_addr[rd_ptr];
                cur_wdata <= q_wdata[rd_ptr];
                lat_cnt   <= LAT_W'(ACCESS_LAT - 1);
            end else if (state == WAIT_LAT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = count != '0 ? WAIT_LAT : IDLE;
            WAIT_LAT: state_nxt = lat_cnt == '0 ? ACCESS : WAIT_LAT;
            ACCESS:   state_nxt = cur_rw ? IDLE : RESPOND;
            RESPOND:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        arr_en    = state == ACCESS;
        arr_we    = arr_en && cur_rw;
        arr_addr  = arr_en ? cur_addr : '0;
        arr_wdata = arr_en ? cur_wdata : '0;
    end

    // Array read data arrives during RESPOND and is registered onto the done outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_l2   <= 1'b0;
            rdata_l2  <= '0;
            done_addr <= '0;
        end else begin
            done_l2   <= state == RESPOND;
            rdata_l2  <= state == RESPOND ? arr_rdata : '0;
            done_addr <= state == RESPOND ? cur_addr : '0;
        end
    end
endmodule

// File: tb/tb_l2_request_responder.sv
// tb_l2_request_responder: directed table plus multi-cycle sequences against a
// behavioural line array with one-cycle read latency.
module tb_l2_request_responder;
    localparam int AW = 32;
    localparam int LW = 128;

    logic          clock = 0, reset = 0, valid_l2 = 0, rw_l2 = 0;
    logic [AW-1:0] addr_l2 = '0;
    logic [LW-1:0] wdata_l2 = '0;
    logic          stall_l2, done_l2, arr_en, arr_we;
    logic [LW-1:0] rdata_l2, arr_wdata;
    logic [LW-1:0] arr_rdata = '0;
    logic [AW-1:0] done_addr, arr_addr;

    l2_request_responder #(.ADDR_W(AW), .LINE_W(LW), .DEPTH(4), .ACCESS_LAT(4)) dut (
        .clock(clock), .reset(reset), .valid_l2(valid_l2), .rw_l2(rw_l2),
        .addr_l2(addr_l2), .wdata_l2(wdata_l2), .stall_l2(stall_l2), .done_l2(done_l2),
        .rdata_l2(rdata_l2), .done_addr(done_addr), .arr_en(arr_en), .arr_we(arr_we),
        .arr_addr(arr_addr), .arr_wdata(arr_wdata), .arr_rdata(arr_rdata)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {logic [AW-1:0] addr; logic [LW-1:0] data; int cyc;} done_t;
    typedef struct {logic we; logic [AW-1:0] addr; logic [LW-1:0] data; int cyc;} arr_t;
    typedef struct {logic rw; logic [AW-1:0] addr; logic [LW-1:0] wdata; logic [LW-1:0] exp;} vec_t;

    done_t dlog[$];
    arr_t  alog[$];
    int    zero_viol = 0, rises = 0, tests = 0, fails = 0;
    logic  prev_stall = 0;
    logic [LW-1:0] mem [int];

    function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
        return {4{32'hC0DE_0000 + a}};
    endfunction

    always @(posedge clock) begin
        if (arr_en) begin
            if (arr_we) mem[int'(arr_addr)] = arr_wdata;
            else arr_rdata <= mem.exists(int'(arr_addr)) ? mem[int'(arr_addr)] : pat(arr_addr);
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (done_l2) dlog.push_back('{done_addr, rdata_l2, cyc});
            else if (rdata_l2 != '0 || done_addr != '0) zero_viol++;
            if (arr_en) alog.push_back('{arr_we, arr_addr, arr_wdata, cyc});
            else if (arr_we || arr_addr != '0 || arr_wdata != '0) zero_viol++;
            if (stall_l2 && !prev_stall) rises++;
            prev_stall = stall_l2;
        end
    end

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with valid_l2 still high.
    task automatic send(input logic rw, input logic [AW-1:0] a, input logic [LW-1:0] d, output int t);
        int b = 50;
        valid_l2 = 1; rw_l2 = rw; addr_l2 = a; wdata_l2 = d;
        while (stall_l2 && b > 0) begin
            @(negedge clock);
            b--;
        end
        if (b == 0) begin
            tests++; fails++;
            $display("FAIL accept_timeout: request %0h never accepted", a);
        end
        t = cyc + 1;
        @(negedge clock);
    endtask

    task automatic chk_rst_outputs(input string tag);
        chk({tag, "_stall"}, LW'(stall_l2), 0);
        chk({tag, "_done"}, LW'(done_l2), 0);
        chk({tag, "_rdata"}, rdata_l2, 0);
        chk({tag, "_done_addr"}, LW'(done_addr), 0);
        chk({tag, "_arr_en"}, LW'(arr_en), 0);
        chk({tag, "_arr_we"}, LW'(arr_we), 0);
        chk({tag, "_arr_addr"}, LW'(arr_addr), 0);
        chk({tag, "_arr_wdata"}, arr_wdata, 0);
    endtask

    initial begin
        vec_t vt[6];
        int   t, t0, t1, nd, na, r0;
        int   ts[6];
        logic [AW-1:0] seq[5];
        vt[0] = '{1'b1, 32'h10, {16{8'hA5}}, 128'h0};
        vt[1] = '{1'b0, 32'h10, 128'h0, {16{8'hA5}}};
        vt[2] = '{1'b0, 32'h20, 128'h0, 128'hC0DE0020_C0DE0020_C0DE0020_C0DE0020};
        vt[3] = '{1'b1, 32'h44, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 128'h0};
        vt[4] = '{1'b0, 32'h44, 128'h0, 128'h01234567_89ABCDEF_FEDCBA98_76543210};
        vt[5] = '{1'b0, 32'h10, 128'h0, {16{8'hA5}}};

        #1 reset = 1;
        #1 chk_rst_outputs("reset");
        repeat (3) @(negedge clock);
        reset = 0;
        @(negedge clock);

        // Isolated transactions: array strobe 2 cycles before done, done at accept + 7.
        for (int i = 0; i < 6; i++) begin
            nd = dlog.size(); na = alog.size();
            send(vt[i].rw, vt[i].addr, vt[i].wdata, t);
            valid_l2 = 0;
            repeat (12) @(negedge clock);
            chk($sformatf("v%0d_arr_cnt", i), LW'(alog.size() - na), 1);
            if (alog.size() > na) begin
                chk($sformatf("v%0d_arr_we", i), LW'(alog[na].we), LW'(vt[i].rw));
                chk($sformatf("v%0d_arr_addr", i), LW'(alog[na].addr), LW'(vt[i].addr));
                chk($sformatf("v%0d_arr_cyc", i), LW'(alog[na].cyc), LW'(t + 5));
                if (vt[i].rw) chk($sformatf("v%0d_arr_wdata", i), alog[na].data, vt[i].wdata);
            end
            chk($sformatf("v%0d_done_cnt", i), LW'(dlog.size() - nd), vt[i].rw ? 0 : 1);
            if (!vt[i].rw && dlog.size() > nd) begin
                chk($sformatf("v%0d_rdata", i), dlog[nd].data, vt[i].exp);
                chk($sformatf("v%0d_done_addr", i), LW'(dlog[nd].addr), LW'(vt[i].addr));
                chk($sformatf("v%0d_done_cyc", i), LW'(dlog[nd].cyc), LW'(t + 7));
            end
        end

        // Six back-to-back reads with valid held high through the stalls.
        nd = dlog.size(); r0 = rises;
        for (int i = 0; i < 6; i++) send(1'b0, AW'(i + 1), '0, ts[i]);
        valid_l2 = 0;
        repeat (50) @(negedge clock);
        chk("b2b_stall_rises", LW'(rises - r0), 2);
        chk("b2b_r6_accept", LW'(ts[5] - ts[0]), 9);
        chk("b2b_done_cnt", LW'(dlog.size() - nd), 6);
        for (int i = 0; i < 6; i++) begin
            if (dlog.size() > nd + i) begin
                chk($sformatf("b2b_addr%0d", i), LW'(dlog[nd+i].addr), LW'(i + 1));
                chk($sformatf("b2b_data%0d", i), dlog[nd+i].data, pat(AW'(i + 1)));
                chk($sformatf("b2b_cyc%0d", i), LW'(dlog[nd+i].cyc), LW'(ts[0] + 7 * (i + 1)));
            end
        end

        // Push and pop on the same edge at count 2, then a fifth accept across the wrap.
        seq = '{32'h51, 32'h52, 32'h53, 32'h54, 32'h55};
        nd = dlog.size();
        send(1'b0, seq[0], '0, t0);
        send(1'b0, seq[1], '0, t);
        send(1'b0, seq[2], '0, t);
        valid_l2 = 0;
        while (cyc < t0 + 7) @(negedge clock);
        chk("pp_count_before", LW'(dut.count), 2);
        send(1'b0, seq[3], '0, t);
        chk("pp_accept_cyc", LW'(t), LW'(t0 + 8));
        chk("pp_count_after", LW'(dut.count), 2);
        chk("pp_stall", LW'(stall_l2), 0);
        send(1'b0, seq[4], '0, t);
        valid_l2 = 0;
        repeat (40) @(negedge clock);
        chk("pp_done_cnt", LW'(dlog.size() - nd), 5);
        for (int i = 0; i < 5; i++)
            if (dlog.size() > nd + i) chk($sformatf("pp_order%0d", i), LW'(dlog[nd+i].addr), LW'(seq[i]));

        // Reset during WAIT_LAT with three requests still queued.
        for (int i = 0; i < 4; i++) send(1'b0, AW'(32'h60 + i), '0, t);
        valid_l2 = 0;
        reset = 1;
        #1 chk_rst_outputs("midrst");
        chk("midrst_count", LW'(dut.count), 0);
        nd = dlog.size();
        @(negedge clock);
        @(negedge clock);
        reset = 0;
        repeat (30) @(negedge clock);
        chk("midrst_no_done", LW'(dlog.size() - nd), 0);
        send(1'b0, 32'h20, '0, t);
        valid_l2 = 0;
        repeat (10) @(negedge clock);
        chk("post_rst_done_cnt", LW'(dlog.size() - nd), 1);
        if (dlog.size() > nd) begin
            chk("post_rst_cyc", LW'(dlog[nd].cyc), LW'(t + 7));
            chk("post_rst_data", dlog[nd].data, 128'hC0DE0020_C0DE0020_C0DE0020_C0DE0020);
        end

        // Writeback immediately followed by a read of the same line.
        nd = dlog.size();
        send(1'b1, 32'h30, 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678, t0);
        send(1'b0, 32'h30, '0, t1);
        valid_l2 = 0;
        repeat (20) @(negedge clock);
        chk("raw_done_cnt", LW'(dlog.size() - nd), 1);
        if (dlog.size() > nd) begin
            chk("raw_data", dlog[nd].data, 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678);
            chk("raw_addr", LW'(dlog[nd].addr), 32'h30);
            chk("raw_cyc", LW'(dlog[nd].cyc), LW'(t0 + 13));
        end

        chk("idle_outputs_zero", LW'(zero_viol), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
